// File: rtl/crc16_tx_seq_pkg.sv
// Shared definitions for the CRC-16 serial transmit sequencer.
//   CRC16_POLY / CRC16_INIT : CRC-16 (x^16+x^12+x^5+1), MSB-first, no reflection
//   CRC16_SYNC              : preamble sync byte (CRC16_TX_PREAMBLE_EN only)
//   state_t                 : sequencer states
//   crc16_step()            : one serial CRC update
// Build option: `define CRC16_TX_PREAMBLE_EN adds the PRE state and sync byte.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

`ifdef CRC16_TX_PREAMBLE_EN
  localparam logic [7:0] CRC16_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_LOAD,
    ST_SHIFT,
    ST_CRC,
    ST_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CRC,
    ST_DONE
  } state_t;
`endif

  // One bit of an MSB-first CRC with no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_tx_seq_if.sv
// Frame request / payload handshake / serial output bundle of crc16_tx_seq.
//   master : frame source + line driver side (start, len, byte_in, byte_valid out)
//   slave  : the sequencer (byte_ready, ser_out, ser_valid, busy, done, crc_out out)
interface crc16_tx_seq_if #(
  parameter int unsigned LEN_W = 8
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;
  logic [15:0]      crc_out;

  modport master (
    output start, len, byte_in, byte_valid,
    input  byte_ready, ser_out, ser_valid, busy, done, crc_out
  );

  modport slave (
    input  start, len, byte_in, byte_valid,
    output byte_ready, ser_out, ser_valid, busy, done, crc_out
  );

endinterface

// File: rtl/crc16_tx_seq_lfsr.sv
// crc16_lfsr: 16-bit serial CRC register, one bit per enabled cycle.
//   clk, reset_n : clock, asynchronous active-low reset (register -> CRC16_INIT)
//   clr          : synchronous clear to CRC16_INIT, wins over en
//   en, din      : advance the CRC with data bit din
//   crc          : current CRC value
module crc16_lfsr
  import crc16_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= CRC16_INIT;
    end else if (clr) begin
      crc_q <= CRC16_INIT;
    end else if (en) begin
      crc_q <= crc16_step(crc_q, din);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc16_tx_seq.sv
// crc16_tx_seq: serial transmit sequencer. Takes a frame length and payload
// bytes over a valid/ready handshake, shifts them out MSB-first on one line
// while feeding each payload bit to a CRC-16, then appends the CRC MSB-first.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : start/len request, byte_in/byte_valid/byte_ready payload
//                  handshake, ser_out/ser_valid serial line, busy, done pulse,
//                  crc_out (CRC of the last completed frame)
// Build option: `define CRC16_TX_PREAMBLE_EN emits sync byte 0xA5 ahead of
// the payload (not covered by the CRC).
// LEN_W must match the LEN_W of the connected interface instance.
module crc16_tx_seq
  import crc16_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  crc16_tx_seq_if.slave   bus
);

  state_t           state_q;
  logic [LEN_W-1:0] bytes_left_q;
  logic [3:0]       cnt_q;        // bit_idx in PRE/SHIFT, remaining CRC bits in CRC
  logic [15:0]      sh_q;         // bits still to send, next one at [15]
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      crc_out_q;

  logic [15:0]      lfsr_crc;
  logic [15:0]      crc_seed_d;
  logic             byte_ready_d;
  logic             hs_d;
  logic             lfsr_clr_d;
  logic             lfsr_en_d;

  // Ready in LOAD, and on the last bit of a byte when more bytes remain so
  // the next byte can follow without a bubble.
  always_comb begin
    byte_ready_d = 1'b0;
    if (state_q == ST_LOAD) begin
      byte_ready_d = 1'b1;
    end else if (state_q == ST_SHIFT && cnt_q == 4'd0 && bytes_left_q != '0) begin
      byte_ready_d = 1'b1;
    end
  end

  assign hs_d       = bus.byte_valid && byte_ready_d;
  assign lfsr_clr_d = (state_q == ST_IDLE) && bus.start;
  assign lfsr_en_d  = (state_q == ST_SHIFT);

  // Value the CRC register holds once the current cycle retires. On the last
  // payload bit the LFSR has not yet absorbed that bit, so the final CRC is
  // taken one step ahead to allow streaming it out with no gap.
  always_comb begin
    crc_seed_d = lfsr_crc;
    if (state_q == ST_IDLE) begin
      crc_seed_d = CRC16_INIT;
    end else if (state_q == ST_SHIFT) begin
      crc_seed_d = crc16_step(lfsr_crc, ser_out_q);
    end
  end

  crc16_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (lfsr_clr_d),
    .en      (lfsr_en_d),
    .din     (ser_out_q),
    .crc     (lfsr_crc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bytes_left_q <= '0;
      cnt_q        <= '0;
      sh_q         <= '0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      crc_out_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            bytes_left_q <= bus.len;
            busy_q       <= 1'b1;
`ifdef CRC16_TX_PREAMBLE_EN
            state_q      <= ST_PRE;
            ser_out_q    <= CRC16_SYNC[7];
            sh_q         <= {CRC16_SYNC[6:0], 9'b0};
            cnt_q        <= 4'd7;
            ser_valid_q  <= 1'b1;
`else
            if (bus.len != '0) begin
              state_q <= ST_LOAD;
            end else begin
              state_q     <= ST_CRC;
              ser_out_q   <= crc_seed_d[15];
              sh_q        <= {crc_seed_d[14:0], 1'b0};
              cnt_q       <= 4'd15;
              ser_valid_q <= 1'b1;
              crc_out_q   <= crc_seed_d;
            end
`endif
          end
        end

`ifdef CRC16_TX_PREAMBLE_EN
        ST_PRE: begin
          if (cnt_q != 4'd0) begin
            ser_out_q <= sh_q[15];
            sh_q      <= {sh_q[14:0], 1'b0};
            cnt_q     <= cnt_q - 4'd1;
          end else if (bytes_left_q != '0) begin
            state_q     <= ST_LOAD;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
          end else begin
            state_q   <= ST_CRC;
            ser_out_q <= crc_seed_d[15];
            sh_q      <= {crc_seed_d[14:0], 1'b0};
            cnt_q     <= 4'd15;
            crc_out_q <= crc_seed_d;
          end
        end
`endif

        ST_LOAD: begin
          if (hs_d) begin
            state_q      <= ST_SHIFT;
            ser_out_q    <= bus.byte_in[7];
            sh_q         <= {bus.byte_in[6:0], 9'b0};
            cnt_q        <= 4'd7;
            ser_valid_q  <= 1'b1;
            bytes_left_q <= bytes_left_q - LEN_W'(1);
          end
        end

        ST_SHIFT: begin
          if (cnt_q != 4'd0) begin
            ser_out_q <= sh_q[15];
            sh_q      <= {sh_q[14:0], 1'b0};
            cnt_q     <= cnt_q - 4'd1;
          end else if (bytes_left_q != '0) begin
            if (hs_d) begin
              ser_out_q    <= bus.byte_in[7];
              sh_q         <= {bus.byte_in[6:0], 9'b0};
              cnt_q        <= 4'd7;
              bytes_left_q <= bytes_left_q - LEN_W'(1);
            end else begin
              state_q     <= ST_LOAD;
              ser_out_q   <= 1'b0;
              ser_valid_q <= 1'b0;
            end
          end else begin
            state_q   <= ST_CRC;
            ser_out_q <= crc_seed_d[15];
            sh_q      <= {crc_seed_d[14:0], 1'b0};
            cnt_q     <= 4'd15;
            crc_out_q <= crc_seed_d;
          end
        end

        ST_CRC: begin
          if (cnt_q != 4'd0) begin
            ser_out_q <= sh_q[15];
            sh_q      <= {sh_q[14:0], 1'b0};
            cnt_q     <= cnt_q - 4'd1;
          end else begin
            state_q     <= ST_DONE;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q     <= ST_IDLE;
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_d;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.crc_out    = crc_out_q;

endmodule
